multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle RV32I control FSM: successor to the single-cycle decoder, sequencing each instruction through fetch, decode, execute, memory and writeback states over a shared datapath and a single memory port with a ready handshake. It drives every datapath strobe and mux select, detects illegal opcodes and memory timeouts, and sits between the instruction register/ALU-flag outputs of the datapath and the unified memory interface.

## Interface
- MEM_TIMEOUT, 15: maximum stall cycles per memory access before trapping; 0 disables the timeout.
- ALUOP_W, 2: width of alu_op.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  load PC.
- ir_write  out  1  load instruction register.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable; meaningful only with mem_req.
- reg_write  out  1  register-file write.
- wb_sel  out  2  writeback source: 00 ALUOut, 01 memory data, 10 PC (return address).
- alu_src_a  out  2  00 PC, 01 rs1, 10 old PC.
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 immediate.
- alu_op  out  ALUOP_W  00 add, 01 subtract, 10 R-type (funct3/funct7), 11 I-type (funct3).
- pc_src  out  1  0 = ALU result, 1 = ALUOut.
- state  out  4  current state encoding.
- trap  out  1  sticky error flag.
- retired  out  1  one-cycle pulse on instruction completion.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 15. Encodings 11–14 are unreachable; if entered, the next state is TRAP.
- Outputs are decoded from state (plus mem_ready/zero/funct3 where noted). Strobes not listed for a state are 0; selects not listed are 00.
- FETCH: mem_req=1, i_or_d=0, a=00, b=01, alu_op=00. On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE: a=10, b=10, alu_op=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 with funct3 000/001 → BRANCH; any other funct3 → TRAP
  - 1101111 → JAL (macro-dependent)
  - anything else → TRAP
- MEMADR: a=01, b=10, alu_op=00; go to MEMRD if opcode[5]=0, else MEMWR.
- MEMRD: mem_req=1, i_or_d=1; on mem_ready go to MEMWB.
- MEMWB: reg_write=1, wb_sel=01, retired=1; go to FETCH.
- MEMWR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready: retired=1, go to FETCH.
- EXEC_R: a=01, b=00, alu_op=10; go to ALUWB. EXEC_I: a=01, b=10, alu_op=11; go to ALUWB.
- ALUWB: reg_write=1, wb_sel=00, retired=1; go to FETCH.
- BRANCH: a=01, b=00, alu_op=01, pc_src=1, pc_write=zero^funct3[0] (beq taken on zero, bne on !zero), retired=1; go to FETCH.
- TRAP: trap=1, all strobes 0; held until rst.
- Memory handshake:
  - mem_req stays asserted until mem_ready is sampled high; mem_ready is ignored while mem_req=0.
  - A stall counter (width clog2(MEM_TIMEOUT+1)) clears on state entry and increments on each mem_req & !mem_ready cycle.
  - When the count reaches MEM_TIMEOUT with mem_ready still low, the next state is TRAP. A mem_ready arriving on that same cycle wins.

## Timing
- Reset: state=FETCH, stall counter=0. While rst is high, all outputs are 0, including mem_req and trap. The first mem_req is asserted the cycle after rst deasserts.
- Zero-wait latency, FETCH entry to retired: lw 5 cycles, sw 4, R-type 4, I-type 4, branch 3, jal 3. Each memory wait cycle adds 1.
- rst asserted mid-instruction aborts it in that cycle; no strobe fires on the rst cycle.
- retired and register/PC writes coincide in the final cycle of the instruction.

## Configuration
- MCU_JAL_EN defined: opcode 1101111 enters JAL.
  - JAL: reg_write=1, wb_sel=10, pc_write=1, pc_src=1, retired=1; go to FETCH.
- MCU_JAL_EN undefined: the JAL state is absent and opcode 1101111 goes to TRAP.

## Test plan
- rst for 2 cycles, then lw (0000011) with mem_ready always high → states 0,1,2,3,4; reg_write=1 with wb_sel=01 in cycle 5; retired pulses once.
- sw with mem_ready delayed 3 cycles in MEMWR → mem_req and mem_we held 4 cycles, then retired; no reg_write.
- beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for beq, 0 for bne; each takes 3 cycles.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH → TRAP entered after 4 stall cycles; trap stays 1 until rst, then FETCH resumes.
- opcode 1111111, and branch with funct3=010 → TRAP directly after DECODE.
- jal with MCU_JAL_EN defined → 3 cycles, reg_write with wb_sel=10 and pc_write. Same stimulus with the macro undefined → trap=1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM driving the shared datapath and single memory port.
// Optional JAL support is enabled by defining MCU_JAL_EN (otherwise jal traps).
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUOP_W     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [6:0]         opcode_i,
  input  logic [2:0]         funct3_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               ir_write_o,
  output logic               i_or_d_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               reg_write_o,
  output logic [1:0]         wb_sel_o,
  output logic [1:0]         alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               pc_src_o,
  output logic [3:0]         state_o,
  output logic               trap_o,
  output logic               retired_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
`ifdef MCU_JAL_EN
    S_JAL    = 4'd10,
`endif
    S_TRAP   = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stalled, timeout_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write_o  = 1'b0;
    ir_write_o  = 1'b0;
    i_or_d_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    reg_write_o = 1'b0;
    wb_sel_o    = 2'b00;
    alu_src_a_o = 2'b00;
    alu_src_b_o = 2'b00;
    alu_op_o    = '0;
    pc_src_o    = 1'b0;
    trap_o      = 1'b0;
    retired_o   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b10;
        case (opcode_i)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXEC_R;
          7'b0010011:             state_d = S_EXEC_I;
          7'b1100011:             state_d = (funct3_i[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
`ifdef MCU_JAL_EN
          7'b1101111:             state_d = S_JAL;
`endif
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        state_d     = opcode_i[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = 2'b01;
        retired_o   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        i_or_d_o  = 1'b1;
        if (mem_ready_i) begin
          retired_o = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a_o = 2'b01;
        alu_op_o    = ALUOP_W'(2'b10);
        state_d     = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        alu_op_o    = ALUOP_W'(2'b11);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        retired_o   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        // funct3[0] distinguishes bne from beq, so it inverts the zero test.
        alu_src_a_o = 2'b01;
        alu_op_o    = ALUOP_W'(2'b01);
        pc_src_o    = 1'b1;
        pc_write_o  = zero_i ^ funct3_i[0];
        retired_o   = 1'b1;
        state_d     = S_FETCH;
      end
`ifdef MCU_JAL_EN
      S_JAL: begin
        reg_write_o = 1'b1;
        wb_sel_o    = 2'b10;
        pc_write_o  = 1'b1;
        pc_src_o    = 1'b1;
        retired_o   = 1'b1;
        state_d     = S_FETCH;
      end
`endif
      S_TRAP: begin
        trap_o  = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase

    // The trap fires on the stall cycle that would bring the count to MEM_TIMEOUT;
    // a ready in that same cycle completes the access instead.
    stalled     = mem_req_o & ~mem_ready_i;
    timeout_hit = (MEM_TIMEOUT != 0) && stalled &&
                  (stall_q == CNT_W'(MEM_TIMEOUT - 1));
    if (timeout_hit) state_d = S_TRAP;

    if (state_d != state_q) stall_d = '0;
    else if (stalled)       stall_d = stall_q + CNT_W'(1);
    else                    stall_d = stall_q;

    state_o = state_q;
    if (rst_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      i_or_d_o    = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      reg_write_o = 1'b0;
      wb_sel_o    = 2'b00;
      alu_src_a_o = 2'b00;
      alu_src_b_o = 2'b00;
      alu_op_o    = '0;
      pc_src_o    = 1'b0;
      trap_o      = 1'b0;
      retired_o   = 1'b0;
      state_o     = 4'd0;
    end
  end

endmodule
